// File: rtl/dvsd_mac_acc.sv
// rtl/dvsd_mac_acc.sv - Saturating multi-term accumulator for multiplier products
//
// Sums a programmed number of 16-bit unsigned products into an ACC_W-bit
// register and presents the result over a valid/ready handshake.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   start, len - launch a job of len terms (sampled in IDLE only)
//   prod, prod_valid, prod_ready - incoming product stream
//   acc, acc_valid, acc_ready    - result handshake
//   overflow   - sticky saturation flag for the current/last job
//   busy       - high while a job is accumulating or awaiting pickup
`timescale 1ns/1ps

module dvsd_mac_acc #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_nxt;
  logic [ACC_W-1:0] acc_nxt;
  logic             overflow_nxt;
  logic [ACC_W:0]   sum;

  // One extra bit so the carry-out directly signals saturation.
  assign sum = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, prod};

  // Handshake outputs depend on state only, never on the partner's valid/ready.
  assign prod_ready = (state == ACCUM);
  assign acc_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      acc      <= acc_nxt;
      overflow <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    acc_nxt      = acc;
    overflow_nxt = overflow;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt      = '0;
          overflow_nxt = 1'b0;
          if (len != '0) begin
            count_nxt = len;
            state_nxt = ACCUM;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          if (sum[ACC_W]) begin
            acc_nxt      = '1;
            overflow_nxt = 1'b1;
          end else begin
            acc_nxt = sum[ACC_W-1:0];
          end
          count_nxt = count - LEN_W'(1);
          // count is loaded non-zero, so leaving at 1 means it never wraps.
          if (count == LEN_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (acc_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dvsd_mac_acc.sv
// tb/tb_dvsd_mac_acc.sv - Scoreboard testbench for dvsd_mac_acc (ACC_W=24 and ACC_W=17)
`timescale 1ns/1ps

module tb_dvsd_mac_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [15:0] prod = '0;
  logic        prod_valid = 1'b0;
  logic        acc_ready = 1'b0;

  logic        prod_ready24, acc_valid24, overflow24, busy24;
  logic [23:0] acc24;
  logic        prod_ready17, acc_valid17, overflow17, busy17;
  logic [16:0] acc17;

  always #5 clk = ~clk;

  dvsd_mac_acc #(.ACC_W(24), .LEN_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready24), .acc(acc24),
    .acc_valid(acc_valid24), .acc_ready(acc_ready), .overflow(overflow24), .busy(busy24)
  );

  dvsd_mac_acc #(.ACC_W(17), .LEN_W(8)) u_sat (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready17), .acc(acc17),
    .acc_valid(acc_valid17), .acc_ready(acc_ready), .overflow(overflow17), .busy(busy17)
  );

  typedef struct {
    logic [23:0] a24;
    logic        o24;
    logic [16:0] a17;
    logic        o17;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] terms[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          xfers = 0;

  always @(posedge clk) begin
    if (!rst && prod_valid && prod_ready24) xfers++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e.a24 = 'x; e.o24 = 1'bx; e.a17 = 'x; e.o17 = 1'bx;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  // Reference model: saturating sums at both widths, pushed when the job starts.
  task automatic start_job(input int l);
    exp_t   e;
    longint s24 = 0;
    longint s17 = 0;
    e.o24 = 1'b0;
    e.o17 = 1'b0;
    foreach (terms[i]) begin
      s24 += terms[i];
      s17 += terms[i];
      if (s24 > 64'd16777215) begin s24 = 64'd16777215; e.o24 = 1'b1; end
      if (s17 > 64'd131071)   begin s17 = 64'd131071;   e.o17 = 1'b1; end
    end
    e.a24 = s24[23:0];
    e.a17 = s17[16:0];
    sb.push_back(e);
    start = 1'b1;
    len   = l[7:0];
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic feed_terms();
    foreach (terms[i]) begin
      prod_valid = 1'b1;
      prod       = terms[i];
      tick();
    end
    prod_valid = 1'b0;
    prod       = '0;
  endtask

  task automatic test_reset();
    int x0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({acc24, acc_valid24, prod_ready24, busy24, overflow24, acc17, overflow17} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got acc=%0d v=%0b r=%0b b=%0b o=%0b exp all zero",
               acc24, acc_valid24, prod_ready24, busy24, overflow24);
    end
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0; len = '0;
    prod_valid = 1'b1; prod = 16'd1000;
    tick();
    prod = 16'd2000;
    tick();
    n_checks++;
    if (acc24 !== 24'd3000 || busy24 !== 1'b1) begin
      n_fail++;
      $display("FAIL midjob_partial got acc=%0d busy=%0b exp acc=3000 busy=1", acc24, busy24);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({acc24, acc_valid24, prod_ready24, busy24} !== '0) begin
      n_fail++;
      $display("FAIL midjob_reset got acc=%0d v=%0b r=%0b b=%0b exp all zero",
               acc24, acc_valid24, prod_ready24, busy24);
    end
    x0 = xfers;
    prod = 16'd3000;
    repeat (3) tick();
    prod_valid = 1'b0;
    n_checks++;
    if (xfers !== x0 || acc24 !== 24'd0 || busy24 !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_ignore got xfers=%0d acc=%0d busy=%0b exp xfers=%0d acc=0 busy=0",
               xfers - x0, acc24, busy24, 0);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    acc_ready = 1'b1;
    terms = '{16'd65025, 16'd1, 16'd100};
    start_job(3);
    feed_terms();
    e = pop_exp();
    n_checks++;
    if (acc_valid24 !== 1'b1 || acc24 !== e.a24 || overflow24 !== e.o24) begin
      n_fail++;
      $display("FAIL basic_result got v=%0b acc=%0d o=%0b exp v=1 acc=%0d o=%0b",
               acc_valid24, acc24, overflow24, e.a24, e.o24);
    end
    tick();
    n_checks++;
    if (acc_valid24 !== 1'b0 || busy24 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle got v=%0b busy=%0b exp 0 0", acc_valid24, busy24);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int   x0;
    acc_ready = 1'b0;
    terms = '{16'd7, 16'd9};
    start_job(2);
    prod_valid = 1'b1; prod = 16'd7;
    tick();
    prod_valid = 1'b0; prod = 16'd9;
    tick();
    tick();
    prod_valid = 1'b1;
    tick();
    e = pop_exp();
    // While held in DONE, stray start and prod_valid must have no effect.
    x0 = xfers;
    start = 1'b1; len = 8'd3; prod = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({acc_valid24, acc24} !== {1'b1, e.a24}) begin
        n_fail++;
        $display("FAIL stall_hold%0d got v=%0b acc=%0d exp v=1 acc=%0d", i, acc_valid24, acc24, e.a24);
      end
      tick();
    end
    acc_ready = 1'b1;
    tick();
    start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0;
    n_checks++;
    if (acc_valid24 !== 1'b0 || busy24 !== 1'b0 || xfers !== x0 || acc24 !== e.a24) begin
      n_fail++;
      $display("FAIL stall_release got v=%0b busy=%0b xfers=%0d acc=%0d exp v=0 busy=0 xfers=0 acc=%0d",
               acc_valid24, busy24, xfers - x0, acc24, e.a24);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    acc_ready = 1'b1;
    terms = '{16'd65025, 16'd65025, 16'd65025};
    start_job(3);
    feed_terms();
    e = pop_exp();
    n_checks++;
    if (acc17 !== e.a17 || overflow17 !== e.o17) begin
      n_fail++;
      $display("FAIL sat17 got acc=%0d o=%0b exp acc=%0d o=%0b", acc17, overflow17, e.a17, e.o17);
    end
    n_checks++;
    if (acc24 !== e.a24 || overflow24 !== e.o24) begin
      n_fail++;
      $display("FAIL sat24 got acc=%0d o=%0b exp acc=%0d o=%0b", acc24, overflow24, e.a24, e.o24);
    end
    tick();
    n_checks++;
    if (overflow17 !== e.o17 || acc17 !== e.a17 || busy17 !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_sticky_idle got o=%0b acc=%0d busy=%0b exp o=%0b acc=%0d busy=0",
               overflow17, acc17, busy17, e.o17, e.a17);
    end
    terms = '{16'd5};
    start_job(1);
    feed_terms();
    e = pop_exp();
    n_checks++;
    if (acc17 !== e.a17 || overflow17 !== e.o17 || acc24 !== e.a24 || acc_valid17 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_clear got acc17=%0d o17=%0b acc24=%0d v=%0b exp %0d %0b %0d 1",
               acc17, overflow17, acc24, acc_valid17, e.a17, e.o17, e.a24);
    end
    tick();
  endtask

  task automatic test_zero_len();
    exp_t e;
    int   x0;
    acc_ready = 1'b0;
    terms = {};
    start_job(0);
    e = pop_exp();
    n_checks++;
    if (acc_valid24 !== 1'b1 || acc24 !== e.a24 || prod_ready24 !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_result got v=%0b acc=%0d r=%0b exp v=1 acc=%0d r=0",
               acc_valid24, acc24, prod_ready24, e.a24);
    end
    x0 = xfers;
    prod_valid = 1'b1; prod = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (prod_ready24 !== 1'b0 || acc_valid24 !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_len_hold%0d got r=%0b v=%0b exp r=0 v=1", i, prod_ready24, acc_valid24);
      end
    end
    acc_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (xfers !== x0 || acc_valid24 !== 1'b0 || prod_ready24 !== 1'b0 || acc24 !== e.a24) begin
      n_fail++;
      $display("FAIL zero_len_noconsume got xfers=%0d v=%0b r=%0b acc=%0d exp 0 0 0 %0d",
               xfers - x0, acc_valid24, prod_ready24, acc24, e.a24);
    end
    prod_valid = 1'b0; prod = '0;
  endtask

  task automatic test_max_len();
    exp_t e;
    int   x0;
    acc_ready = 1'b1;
    terms = {};
    repeat (255) terms.push_back(16'd65025);
    x0 = xfers;
    start_job(255);
    feed_terms();
    e = pop_exp();
    n_checks++;
    if (acc_valid24 !== 1'b1 || acc24 !== e.a24 || overflow24 !== e.o24) begin
      n_fail++;
      $display("FAIL max_len_result got v=%0b acc=%0d o=%0b exp v=1 acc=%0d o=%0b",
               acc_valid24, acc24, overflow24, e.a24, e.o24);
    end
    n_checks++;
    if (xfers - x0 !== 255) begin
      n_fail++;
      $display("FAIL max_len_xfers got %0d exp 255", xfers - x0);
    end
    n_checks++;
    if (acc17 !== e.a17 || overflow17 !== e.o17) begin
      n_fail++;
      $display("FAIL max_len_sat17 got acc=%0d o=%0b exp acc=%0d o=%0b", acc17, overflow17, e.a17, e.o17);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   l;
    acc_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      l = $urandom_range(1, 8);
      terms = {};
      for (int k = 0; k < l; k++) terms.push_back(16'($urandom_range(0, 65535)));
      start_job(l);
      feed_terms();
      e = pop_exp();
      n_checks++;
      if (acc_valid24 !== 1'b1 || acc24 !== e.a24 || acc17 !== e.a17 || overflow17 !== e.o17) begin
        n_fail++;
        $display("FAIL b2b_job%0d got v=%0b acc24=%0d acc17=%0d o17=%0b exp v=1 %0d %0d %0b",
                 j, acc_valid24, acc24, acc17, overflow17, e.a24, e.a17, e.o17);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_saturation();
    test_zero_len();
    test_max_len();
    test_back_to_back();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
